// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader_pkg
//  Description : Shared definitions for the FIFO test read-side burst
//                controller and its writer-side companion: FSM state
//                encodings, default sizing constants and a saturating
//                16-bit counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_burst_reader_pkg;

    // FSM state encodings, common to reader and writer controllers
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // Default sizing
    localparam int c_BURST_LEN_DEF = 128;
    localparam int c_LVL_W_DEF     = 9;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_pattern_chk.sv
`default_nettype none
// ============================================================================
//  Module      : burst_pattern_chk
//  Description : Checks each burst word against the incrementing pattern
//                1..BURST_LEN. It observes words on the edge they are
//                loaded into the output register, so mismatch/burst_done
//                line up with the top-level out_valid cycle.
//  Ports       : clk, rst_n        - clock, synchronous active-low reset
//                i_valid           - a word is being loaded this edge
//                i_data            - the word being loaded
//                i_last            - this is the last word of the burst
//                o_mismatch        - word differs from expected (pulse)
//                o_burst_done      - last word of a burst (pulse)
//                o_burst_cnt       - completed bursts, wrapping
//                o_err_cnt         - mismatched words, saturating
//  Revision    : 1.0 - initial release
// ============================================================================
module burst_pattern_chk
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_mismatch,
    output logic              o_burst_done,
    output logic [15:0]       o_burst_cnt,
    output logic [15:0]       o_err_cnt
);

    logic [DATA_W-1:0] r_expected_q;
    logic [DATA_W-1:0] w_expected_d;
    logic              r_mismatch_q;
    logic              w_mismatch_d;
    logic              r_burst_done_q;
    logic              w_burst_done_d;
    logic [15:0]       r_burst_cnt_q;
    logic [15:0]       w_burst_cnt_d;
    logic [15:0]       r_err_cnt_q;
    logic [15:0]       w_err_cnt_d;

    always_comb begin
        w_expected_d   = r_expected_q;
        w_mismatch_d   = 1'b0;
        w_burst_done_d = 1'b0;
        w_burst_cnt_d  = r_burst_cnt_q;
        w_err_cnt_d    = r_err_cnt_q;
        if (i_valid) begin
            w_mismatch_d = (i_data != r_expected_q);
            if (w_mismatch_d) begin
                w_err_cnt_d = sat_inc16(r_err_cnt_q);
            end
            if (i_last) begin
                // Every burst restarts the pattern at 1
                w_expected_d   = DATA_W'(1);
                w_burst_done_d = 1'b1;
                w_burst_cnt_d  = r_burst_cnt_q + 16'd1;
            end else begin
                w_expected_d = r_expected_q + DATA_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_expected_q   <= DATA_W'(1);
            r_mismatch_q   <= 1'b0;
            r_burst_done_q <= 1'b0;
            r_burst_cnt_q  <= 16'd0;
            r_err_cnt_q    <= 16'd0;
        end else begin
            r_expected_q   <= w_expected_d;
            r_mismatch_q   <= w_mismatch_d;
            r_burst_done_q <= w_burst_done_d;
            r_burst_cnt_q  <= w_burst_cnt_d;
            r_err_cnt_q    <= w_err_cnt_d;
        end
    end

    assign o_mismatch   = r_mismatch_q;
    assign o_burst_done = r_burst_done_q;
    assign o_burst_cnt  = r_burst_cnt_q;
    assign o_err_cnt    = r_err_cnt_q;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Read-side burst controller for the FIFO test design. Waits
//                until at least BURST_LEN words are stored, issues exactly
//                BURST_LEN consecutive read enables, re-times returned data
//                into a valid-qualified stream and checks it against the
//                incrementing test pattern.
//  Ports       : sys_clk, rst_n    - clock, synchronous active-low reset
//                enable            - permits new bursts to start
//                rd_water_level    - FIFO read-side fill level
//                fifo_rd_data      - FIFO read data
//                fifo_rd_en        - FIFO read enable
//                out_valid/out_data- registered burst word stream
//                mismatch          - current out_data differs from pattern
//                burst_done        - pulse on the last word of a burst
//                burst_cnt         - completed bursts (wraps)
//                err_cnt           - mismatched words (saturates)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LVL_W     = c_LVL_W_DEF,
    parameter int BURST_LEN = c_BURST_LEN_DEF,
    parameter int RD_LAT    = 1
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [LVL_W-1:0]  rd_water_level,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              mismatch,
    output logic              burst_done,
    output logic [15:0]       burst_cnt,
    output logic [15:0]       err_cnt
);

    localparam logic [LVL_W-1:0] c_LVL_NEED   = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] c_RD_LAST    = LVL_W'(BURST_LEN - 1);
    // DRAIN lasts RD_LAT+1 cycles: drain count runs 0..RD_LAT
    localparam logic [1:0]       c_DRAIN_LAST = 2'(RD_LAT);

    logic [1:0]        r_state_q;
    logic [1:0]        w_state_d;
    logic [LVL_W-1:0]  r_rd_cnt_q;
    logic [LVL_W-1:0]  w_rd_cnt_d;
    logic [1:0]        r_drain_cnt_q;
    logic [1:0]        w_drain_cnt_d;
    logic              r_rd_en_q;
    logic              w_rd_en_d;
    logic [RD_LAT-1:0] r_en_dly_q;
    logic [RD_LAT-1:0] w_en_dly_d;
    logic [RD_LAT-1:0] r_last_dly_q;
    logic [RD_LAT-1:0] w_last_dly_d;
    logic              r_out_valid_q;
    logic              w_out_valid_d;
    logic [DATA_W-1:0] r_out_data_q;
    logic [DATA_W-1:0] w_out_data_d;

    logic              w_rd_last;
    logic              w_load;
    logic              w_load_last;

    // ------------------------------------------------------------------
    // Burst FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_rd_cnt_d    = r_rd_cnt_q;
        w_drain_cnt_d = r_drain_cnt_q;
        w_rd_en_d     = 1'b0;
        case (r_state_q)
            c_ST_IDLE: begin
                if (enable && (rd_water_level >= c_LVL_NEED)) begin
                    w_state_d  = c_ST_READ;
                    w_rd_en_d  = 1'b1;
                    w_rd_cnt_d = '0;
                end
            end
            c_ST_READ: begin
                // enable is ignored here: a started burst always completes
                if (r_rd_cnt_q == c_RD_LAST) begin
                    w_state_d     = c_ST_DRAIN;
                    w_drain_cnt_d = 2'd0;
                end else begin
                    w_rd_en_d  = 1'b1;
                    w_rd_cnt_d = r_rd_cnt_q + LVL_W'(1);
                end
            end
            c_ST_DRAIN: begin
                // Gives the FIFO time to update its level before re-arming
                if (r_drain_cnt_q == c_DRAIN_LAST) begin
                    w_state_d = c_ST_IDLE;
                end else begin
                    w_drain_cnt_d = r_drain_cnt_q + 2'd1;
                end
            end
            default: begin
                w_state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-enable delay line, with a parallel last-word marker so the
    // checker knows which returned word closes the burst.
    // ------------------------------------------------------------------
    assign w_rd_last = r_rd_en_q && (r_rd_cnt_q == c_RD_LAST);

    always_comb begin
        w_en_dly_d      = '0;
        w_last_dly_d    = '0;
        w_en_dly_d[0]   = r_rd_en_q;
        w_last_dly_d[0] = w_rd_last;
        for (int i = 1; i < RD_LAT; i++) begin
            w_en_dly_d[i]   = r_en_dly_q[i-1];
            w_last_dly_d[i] = r_last_dly_q[i-1];
        end
    end

    assign w_load      = r_en_dly_q[RD_LAT-1];
    assign w_load_last = r_last_dly_q[RD_LAT-1];

    always_comb begin
        w_out_valid_d = w_load;
        w_out_data_d  = w_load ? fifo_rd_data : r_out_data_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state_q     <= c_ST_IDLE;
            r_rd_cnt_q    <= '0;
            r_drain_cnt_q <= 2'd0;
            r_rd_en_q     <= 1'b0;
            r_en_dly_q    <= '0;
            r_last_dly_q  <= '0;
            r_out_valid_q <= 1'b0;
            r_out_data_q  <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_rd_cnt_q    <= w_rd_cnt_d;
            r_drain_cnt_q <= w_drain_cnt_d;
            r_rd_en_q     <= w_rd_en_d;
            r_en_dly_q    <= w_en_dly_d;
            r_last_dly_q  <= w_last_dly_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_data_q  <= w_out_data_d;
        end
    end

    // Checker sees the word as it is loaded, so its registered flags
    // coincide with out_valid.
    burst_pattern_chk #(
        .DATA_W (DATA_W)
    ) u_chk (
        .clk          (sys_clk),
        .rst_n        (rst_n),
        .i_valid      (w_load),
        .i_data       (fifo_rd_data),
        .i_last       (w_load_last),
        .o_mismatch   (mismatch),
        .o_burst_done (burst_done),
        .o_burst_cnt  (burst_cnt),
        .o_err_cnt    (err_cnt)
    );

    assign fifo_rd_en = r_rd_en_q;
    assign out_valid  = r_out_valid_q;
    assign out_data   = r_out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Directed self-checking bench for fifo_burst_reader with a
//                RD_LAT=1 FIFO model returning 1..128 per burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [8:0]  rd_water_level;
    logic [7:0]  fifo_rd_data;
    logic        fifo_rd_en;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        mismatch;
    logic        burst_done;
    logic [15:0] burst_cnt;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    fifo_burst_reader #(
        .DATA_W    (8),
        .LVL_W     (9),
        .BURST_LEN (128),
        .RD_LAT    (1)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .rd_water_level (rd_water_level),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_en     (fifo_rd_en),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .mismatch       (mismatch),
        .burst_done     (burst_done),
        .burst_cnt      (burst_cnt),
        .err_cnt        (err_cnt)
    );

    // FIFO model: one-cycle read latency, word n of each burst is n+1,
    // optional corruption of word 64 (index 63) to 0xFF.
    logic [7:0] r_ridx;
    logic       corrupt_en;
    always @(posedge sys_clk) begin
        if (!rst_n) begin
            r_ridx       <= 8'd0;
            fifo_rd_data <= 8'd0;
        end else if (fifo_rd_en) begin
            fifo_rd_data <= (corrupt_en && r_ridx == 8'd63) ? 8'hFF : r_ridx + 8'd1;
            r_ridx       <= (r_ridx == 8'd127) ? 8'd0 : r_ridx + 8'd1;
        end
    end

    // Observation statistics, updated once per cycle by tick()
    int   cyc = 0;
    int   n_rd, n_rise, n_valid, n_mis, mis_pos, n_done, done_bad;
    int   data_bad, stray, t_rd_first, t_valid_first, t_done, last_done;
    int   n_gap, gap_bad, vpos;
    logic prev_rd_en = 1'b0;

    task automatic clear_stats();
        n_rd = 0; n_rise = 0; n_valid = 0; n_mis = 0; mis_pos = -1;
        n_done = 0; done_bad = 0; data_bad = 0; stray = 0;
        t_rd_first = -1; t_valid_first = -1; t_done = -1; last_done = -1;
        n_gap = 0; gap_bad = 0; vpos = 0;
    endtask

    task automatic tick();
        logic [7:0] expv;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (!rst_n) vpos = 0;
        if (fifo_rd_en) begin
            n_rd++;
            if (!prev_rd_en) begin
                n_rise++;
                if (t_rd_first < 0) t_rd_first = cyc;
                if (last_done >= 0) begin
                    n_gap++;
                    if (cyc - last_done != 2) gap_bad++;
                end
            end
        end
        prev_rd_en = fifo_rd_en;
        if (out_valid) begin
            n_valid++;
            if (t_valid_first < 0) t_valid_first = cyc;
            expv = (corrupt_en && vpos == 63) ? 8'hFF : 8'(vpos + 1);
            if (out_data !== expv) data_bad++;
            if (mismatch === 1'b1) begin
                n_mis++;
                mis_pos = vpos;
            end
            if (burst_done === 1'b1) begin
                n_done++;
                if (vpos != 127) done_bad++;
                t_done    = cyc;
                last_done = cyc;
            end
            vpos = (vpos == 127) ? 0 : vpos + 1;
        end else if (mismatch !== 1'b0 || burst_done !== 1'b0) begin
            stray++;
        end
    endtask

    task automatic wait_rises(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_rise >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_dones(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (n_done >= target) ok = 1'b1;
        end
    endtask

    // One burst: raise level, drop it once reading starts, wait for done
    task automatic run_burst(output bit ok);
        bit ok1, ok2;
        rd_water_level = 9'd128;
        wait_rises(n_rise + 1, 20, ok1);
        rd_water_level = 9'd0;
        wait_dones(n_done + 1, 200, ok2);
        repeat (4) tick();
        ok = ok1 && ok2;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; rd_water_level = 9'd0; corrupt_en = 1'b0;
        clear_stats();
        repeat (3) tick();
        checks++;
        if ({fifo_rd_en, out_valid, mismatch, burst_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {fifo_rd_en, out_valid, mismatch, burst_done});
        end
        checks++;
        if ({out_data, burst_cnt, err_cnt} !== 40'd0) begin
            errors++;
            $display("FAIL reset_values out_data=%0h burst_cnt=%0d err_cnt=%0d want 0", out_data, burst_cnt, err_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_below_threshold();
        clear_stats();
        enable = 1'b1;
        rd_water_level = 9'd127;
        repeat (50) tick();
        checks++;
        if (n_rd != 0) begin
            errors++; $display("FAIL below_rd_en got %0d want 0", n_rd);
        end
        checks++;
        if (n_valid != 0) begin
            errors++; $display("FAIL below_out_valid got %0d want 0", n_valid);
        end
        rd_water_level = 9'd0;
    endtask

    task automatic test_single_burst();
        bit ok;
        clear_stats();
        run_burst(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got %0d want 1", ok); end
        checks++;
        if (n_rd != 128) begin errors++; $display("FAIL single_rd_en_cycles got %0d want 128", n_rd); end
        checks++;
        if (n_valid != 128) begin errors++; $display("FAIL single_words got %0d want 128", n_valid); end
        checks++;
        if (data_bad != 0) begin errors++; $display("FAIL single_data got %0d bad words want 0", data_bad); end
        checks++;
        if (n_mis != 0) begin errors++; $display("FAIL single_mismatch got %0d want 0", n_mis); end
        checks++;
        if (n_done != 1 || done_bad != 0) begin
            errors++; $display("FAIL single_done got %0d (misplaced %0d) want 1 (0)", n_done, done_bad);
        end
        checks++;
        if (burst_cnt !== 16'd1) begin errors++; $display("FAIL single_burst_cnt got %0d want 1", burst_cnt); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL single_err_cnt got %0d want 0", err_cnt); end
        checks++;
        if (t_valid_first - t_rd_first != 2) begin
            errors++; $display("FAIL single_first_latency got %0d want 2", t_valid_first - t_rd_first);
        end
        checks++;
        if (t_done - t_rd_first != 129) begin
            errors++; $display("FAIL single_done_latency got %0d want 129", t_done - t_rd_first);
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL single_stray_pulses got %0d want 0", stray); end
    endtask

    task automatic test_corrupt_word();
        bit ok;
        corrupt_en = 1'b1;
        clear_stats();
        run_burst(ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL corrupt_timeout got %0d want 1", ok); end
        checks++;
        if (n_mis != 1 || mis_pos != 63) begin
            errors++; $display("FAIL corrupt_mismatch got count %0d index %0d want 1 index 63", n_mis, mis_pos);
        end
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL corrupt_err_cnt got %0d want 1", err_cnt); end
        checks++;
        if (n_done != 1 || burst_cnt !== 16'd2) begin
            errors++; $display("FAIL corrupt_done got %0d burst_cnt %0d want 1 and 2", n_done, burst_cnt);
        end
        checks++;
        if (data_bad != 0) begin errors++; $display("FAIL corrupt_data got %0d bad words want 0", data_bad); end
        // Next burst is clean and must check from 1 again
        corrupt_en = 1'b0;
        clear_stats();
        run_burst(ok);
        checks++;
        if (ok !== 1'b1 || n_mis != 0) begin
            errors++; $display("FAIL recheck_mismatch got %0d (ok %0d) want 0", n_mis, ok);
        end
        checks++;
        if (err_cnt !== 16'd1 || burst_cnt !== 16'd3) begin
            errors++; $display("FAIL recheck_counters got err %0d bursts %0d want 1 and 3", err_cnt, burst_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        clear_stats();
        rd_water_level = 9'd200;
        wait_rises(3, 400, ok1);
        rd_water_level = 9'd0;
        wait_dones(3, 300, ok2);
        repeat (4) tick();
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout got %0d%0d want 11", ok1, ok2); end
        checks++;
        if (n_done != 3) begin errors++; $display("FAIL b2b_done got %0d want 3", n_done); end
        checks++;
        if (n_gap != 2 || gap_bad != 0) begin
            errors++; $display("FAIL b2b_gap got %0d gaps %0d wrong want 2 gaps 0 wrong", n_gap, gap_bad);
        end
        checks++;
        if (n_rd != 384 || n_valid != 384) begin
            errors++; $display("FAIL b2b_words got rd %0d valid %0d want 384", n_rd, n_valid);
        end
        checks++;
        if (burst_cnt !== 16'd6) begin errors++; $display("FAIL b2b_burst_cnt got %0d want 6", burst_cnt); end
        checks++;
        if (data_bad != 0 || n_mis != 0) begin
            errors++; $display("FAIL b2b_data got bad %0d mis %0d want 0", data_bad, n_mis);
        end
    endtask

    task automatic test_enable_drop();
        bit ok1, ok2;
        clear_stats();
        enable = 1'b1;
        rd_water_level = 9'd128;
        wait_rises(1, 20, ok1);
        repeat (10) tick();
        enable = 1'b0;
        wait_dones(1, 200, ok2);
        repeat (20) tick();
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL endrop_timeout got %0d%0d want 11", ok1, ok2); end
        checks++;
        if (n_rd != 128 || n_valid != 128) begin
            errors++; $display("FAIL endrop_words got rd %0d valid %0d want 128", n_rd, n_valid);
        end
        checks++;
        if (n_rise != 1) begin errors++; $display("FAIL endrop_restart got %0d bursts want 1", n_rise); end
        checks++;
        if (burst_cnt !== 16'd7 || data_bad != 0) begin
            errors++; $display("FAIL endrop_result got bursts %0d bad %0d want 7 and 0", burst_cnt, data_bad);
        end
        rd_water_level = 9'd0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clear_stats();
        rd_water_level = 9'd128;
        wait_rises(1, 20, ok);
        repeat (49) tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (ok !== 1'b1 || fifo_rd_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got ok %0d rd_en %b valid %b want 1 0 0", ok, fifo_rd_en, out_valid);
        end
        checks++;
        if (burst_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL midrst_counters got bursts %0d err %0d want 0", burst_cnt, err_cnt);
        end
        rd_water_level = 9'd0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        clear_stats();
        run_burst(ok);
        checks++;
        if (ok !== 1'b1 || n_valid != 128 || data_bad != 0) begin
            errors++; $display("FAIL midrst_reburst got ok %0d words %0d bad %0d want 1 128 0", ok, n_valid, data_bad);
        end
        checks++;
        if (n_mis != 0 || err_cnt !== 16'd0 || burst_cnt !== 16'd1) begin
            errors++; $display("FAIL midrst_recount got mis %0d err %0d bursts %0d want 0 0 1", n_mis, err_cnt, burst_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_below_threshold();
        test_single_burst();
        test_corrupt_word();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
